// File: rtl/row_run_encoder.sv
// rtl/row_run_encoder.sv - compresses a rasterizer point stream into buffered row run records
module run_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int W     = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_valid,
    input  logic [W-1:0] wr_data,
    input  logic         rd_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic         overflow
);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign rd_valid = (count != '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = rd_valid && rd_ready;
    // a full queue still takes a record when the head leaves on the same edge
    assign do_push  = wr_valid && (!full || do_pop);
    // head fields read as zero while empty so reset shows all-zero outputs
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // storage array needs no reset; only entries behind count are ever visible
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers wrap naturally at DEPTH; overflow latches until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_valid && full && !do_pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

module row_run_encoder #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic signed [7:0] xi,
    input  logic signed [7:0] yi,
    input  logic              out_ready,
    output logic              out_valid,
    output logic signed [7:0] run_y,
    output logic signed [7:0] run_x,
    output logic        [8:0] run_len,
    output logic              run_last,
    output logic              overflow
);
    typedef enum logic {S_IDLE = 1'b0, S_OPEN = 1'b1} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cur_y;
    logic [7:0]  cur_x0;
    logic [7:0]  last_x;
    logic [8:0]  len;
    logic        cont;
    logic        load;
    logic        extend;
    logic        push;
    logic        push_last;
    logic [25:0] push_data;
    logic [25:0] head_data;

    // 9-bit compare keeps 127 -> -128 from looking like a +1 step
    assign cont = (yi == cur_y) && ({xi[7], xi} == ({last_x[7], last_x} + 9'd1));
    assign push_data = {cur_y, cur_x0, len, push_last};

    // run builder state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // a dropped in_valid ends the frame; any point keeps or reopens a run
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_OPEN;
            S_OPEN:  if (!in_valid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // decode run builder actions: load a new run, extend it, or emit a record
    always_comb begin
        load      = 1'b0;
        extend    = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        case (state)
            S_IDLE: begin
                load = in_valid;
            end
            S_OPEN: begin
                if (in_valid) begin
                    if (cont) begin
                        extend = 1'b1;
                    end else begin
                        push = 1'b1;
                        load = 1'b1;
                    end
                end else begin
                    push      = 1'b1;
                    push_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // open-run registers; len reaches 256 for a full row without saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_y  <= '0;
            cur_x0 <= '0;
            last_x <= '0;
            len    <= '0;
        end else if (load) begin
            cur_y  <= yi;
            cur_x0 <= xi;
            last_x <= xi;
            len    <= 9'd1;
        end else if (extend) begin
            last_x <= xi;
            len    <= len + 9'd1;
        end
    end

    run_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .W     (26)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (push),
        .wr_data  (push_data),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (head_data),
        .overflow (overflow)
    );

    assign {run_y, run_x, run_len, run_last} = head_data;
endmodule

// File: tb/tb_row_run_encoder.sv
// tb/tb_row_run_encoder.sv - randomized and directed checks of row_run_encoder against a queue model
module tb_row_run_encoder;
    localparam int DEPTH = 4;

    typedef struct {
        int y;
        int x;
        int len;
        bit last;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] xi;
    logic [7:0] yi;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] run_y;
    logic [7:0] run_x;
    logic [8:0] run_len;
    logic       run_last;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // model: open run as plain integers, FIFO as a bounded queue
    bit   m_open = 0;
    int   m_y, m_x0, m_lastx, m_len;
    bit   m_ovf = 0;
    rec_t mq[$];
    rec_t got[$];

    row_run_encoder #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .xi        (xi),
        .yi        (yi),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .run_y     (run_y),
        .run_x     (run_x),
        .run_len   (run_len),
        .run_last  (run_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_open = 0;
        m_ovf  = 0;
        mq.delete();
    endtask

    // one clock edge of the model, fed with the inputs held across that edge
    task automatic model_edge(input bit v, input int x, input int y, input bit rdy);
        rec_t r;
        bit   do_push = 0;
        bit   do_pop  = (mq.size() != 0) && rdy;
        if (m_open && v && y == m_y && x == m_lastx + 1) begin
            m_lastx = x;
            m_len++;
        end else begin
            if (m_open) begin
                r.y = m_y; r.x = m_x0; r.len = m_len; r.last = !v;
                do_push = 1;
            end
            m_open = v;
            if (v) begin
                m_y = y; m_x0 = x; m_lastx = x; m_len = 1;
            end
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_state();
        check_eq("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check_eq("run_y", $signed(run_y), mq[0].y);
            check_eq("run_x", $signed(run_x), mq[0].x);
            check_eq("run_len", run_len, mq[0].len);
            check_eq("run_last", run_last, mq[0].last);
        end
        check_eq("overflow", overflow, m_ovf);
    endtask

    // drive one cycle: inputs after the falling edge, compare at the next falling edge
    task automatic step(input bit v, input int x, input int y, input bit rdy);
        rec_t r;
        in_valid  = v;
        xi        = x[7:0];
        yi        = y[7:0];
        out_ready = rdy;
        #1;
        if (out_valid && rdy) begin
            r.y = $signed(run_y); r.x = $signed(run_x); r.len = run_len; r.last = run_last;
            got.push_back(r);
        end
        @(posedge clk);
        model_edge(v, x, y, rdy);
        @(negedge clk);
        compare_state();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy);
    endtask

    task automatic check_rec(input string tag, input int idx, input int y, input int x,
                             input int len, input bit last);
        if (got.size() > idx) begin
            check_eq({tag, ".y"}, got[idx].y, y);
            check_eq({tag, ".x"}, got[idx].x, x);
            check_eq({tag, ".len"}, got[idx].len, len);
            check_eq({tag, ".last"}, got[idx].last, last);
        end else begin
            check_eq({tag, ".count"}, got.size(), idx + 1);
        end
    endtask

    initial begin
        int x, y, n, pick;
        bit rdy_bias;
        rst = 1'b1; in_valid = 1'b0; xi = '0; yi = '0; out_ready = 1'b0;
        @(negedge clk);
        check_eq("reset.out_valid", out_valid, 0);
        check_eq("reset.run_y", run_y, 0);
        check_eq("reset.run_x", run_x, 0);
        check_eq("reset.run_len", run_len, 0);
        check_eq("reset.run_last", run_last, 0);
        check_eq("reset.overflow", overflow, 0);
        rst = 1'b0;
        model_reset();

        // two rows in one frame
        got.delete();
        step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 2, 0, 1);
        step(1, -1, 1, 1); step(1, 0, 1, 1); step(1, 1, 1, 1); step(1, 2, 1, 1); step(1, 3, 1, 1);
        idle(3, 1);
        check_eq("t1.count", got.size(), 2);
        check_rec("t1.r0", 0, 0, 0, 3, 0);
        check_rec("t1.r1", 1, 1, -1, 5, 1);

        // single-point frame
        got.delete();
        step(1, 5, -7, 1);
        idle(2, 1);
        check_rec("t2.r0", 0, -7, 5, 1, 1);

        // gap in a row
        got.delete();
        step(1, 0, 2, 1); step(1, 1, 2, 1); step(1, 3, 2, 1); step(1, 4, 2, 1);
        idle(2, 1);
        check_rec("t3.r0", 0, 2, 0, 2, 0);
        check_rec("t3.r1", 1, 2, 3, 2, 1);

        // 127 -> -128 is not a continuation
        got.delete();
        step(1, 126, 0, 1); step(1, 127, 0, 1); step(1, -128, 0, 1);
        idle(2, 1);
        check_rec("t4.r0", 0, 0, 126, 2, 0);
        check_rec("t4.r1", 1, 0, -128, 1, 1);

        // full 256-point row
        got.delete();
        for (int i = -128; i < 128; i++) step(1, i, 3, 1);
        idle(2, 1);
        check_rec("t5.r0", 0, 3, -128, 256, 1);

        // overflow: six single-point rows with no consumer
        got.delete();
        for (int i = 0; i < 6; i++) step(1, 0, i, 0);
        idle(1, 0);
        check_eq("t6.overflow", overflow, 1);
        check_eq("t6.out_valid", out_valid, 1);
        idle(5, 1);
        check_eq("t6.count", got.size(), 4);
        for (int i = 0; i < 4; i++) check_rec("t6.r", i, i, 0, 1, 0);
        check_eq("t6.drained", out_valid, 0);

        // asynchronous reset mid-frame with two records queued
        step(1, 0, 0, 0); step(1, 0, 1, 0); step(1, 0, 2, 0);
        check_eq("t7.pre_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("t7.async_valid", out_valid, 0);
        check_eq("t7.async_ovf", overflow, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        got.delete();
        step(1, 9, 9, 1); step(1, 10, 9, 1);
        idle(3, 1);
        check_eq("t7.count", got.size(), 1);
        check_rec("t7.r0", 0, 9, 9, 2, 1);

        // randomized frames with random consumer
        for (int f = 0; f < 150; f++) begin
            n = $urandom_range(1, 12);
            x = int'($urandom_range(0, 255)) - 128;
            y = int'($urandom_range(0, 255)) - 128;
            rdy_bias = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) begin
                step(1, x, y, rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
                pick = $urandom_range(0, 9);
                if (pick < 7) begin
                    x = (x == 127) ? -128 : x + 1;
                end else if (pick == 7) begin
                    y = (y == 127) ? -128 : y + 1;
                end else if (pick == 8) begin
                    x = int'($urandom_range(0, 255)) - 128;
                end
            end
            idle($urandom_range(1, 3), $urandom_range(0, 1));
        end
        idle(8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
